// File: rtl/armleocpu_skid_fifo.sv
// armleocpu_skid_fifo
//   DEPTH-entry decoupling buffer between two valid/ready/data domains.
//   The head entry lives in a dedicated register (out_valid/out_data). The
//   remaining DEPTH-1 entries live in a circular buffer behind it. in_ready
//   is decoded from the registered occupancy only, so no combinational path
//   runs from the input side to the output side or back.
//
// Parameters
//   PASSTHROUGH  1: plain wires, no state (level reads 0)
//   DW           data width
//   DEPTH        total capacity including the head register, 2..256
//
// Ports
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   in_valid     producer valid
//   in_data      producer data
//   in_ready     level != DEPTH
//   out_valid    registered, head entry valid
//   out_data     registered head entry
//   out_ready    consumer accepts the head
//   level        registered occupancy, 0..DEPTH
//   flush        present only when ARMLEOCPU_SKID_FIFO_FLUSH_EN is defined;
//                empties the buffer on the next edge, overriding push/pop
module armleocpu_skid_fifo #(
   parameter int PASSTHROUGH = 0,
   parameter int DW          = 8,
   parameter int DEPTH       = 2,
   localparam int LW         = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [DW-1:0] in_data,
   output logic          in_ready,
   output logic          out_valid,
   output logic [DW-1:0] out_data,
   input  logic          out_ready,
   output logic [LW-1:0] level
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
   ,
   input  logic          flush
`endif
);

   generate
      if (PASSTHROUGH != 0) begin : g_pass
         assign out_valid = in_valid;
         assign out_data  = in_data;
         assign in_ready  = out_ready;
         assign level     = '0;
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
         logic unused_pass;
         assign unused_pass = clk ^ rst_n ^ flush;
`else
         logic unused_pass;
         assign unused_pass = clk ^ rst_n;
`endif
      end else begin : g_fifo
         localparam int BN = DEPTH - 1;
         localparam int PW = (BN > 1) ? $clog2(BN) : 1;
         localparam logic [PW-1:0] PTR_LAST = PW'(BN - 1);

         logic [DW-1:0] mem [BN];
         logic [PW-1:0] rd_ptr, wr_ptr;
         logic          head_valid;
         logic [DW-1:0] head_data;
         logic [LW-1:0] lvl_q;

         logic push, pop, buf_empty, buf_wr, head_from_buf, head_from_in;

         // Pointers wrap at BN-1 so non-power-of-two depths work.
         function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
            return (p == PTR_LAST) ? '0 : p + 1'b1;
         endfunction

         always_comb begin
            push          = in_valid & in_ready;
            pop           = head_valid & out_ready;
            // With a valid head, buffer occupancy is level-1.
            buf_empty     = (lvl_q <= LW'(1));
            // Incoming word goes to the buffer unless the head is (or is
            // about to become) empty with nothing queued ahead of it.
            buf_wr        = push & head_valid & ~(pop & buf_empty);
            head_from_buf = pop & ~buf_empty;
            head_from_in  = push & ~buf_wr;
         end

         assign in_ready  = (lvl_q != LW'(DEPTH));
         assign out_valid = head_valid;
         assign out_data  = head_data;
         assign level     = lvl_q;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               head_valid <= 1'b0;
               head_data  <= '0;
               lvl_q      <= '0;
               rd_ptr     <= '0;
               wr_ptr     <= '0;
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
            end else if (flush) begin
               // head_data deliberately keeps its last value
               head_valid <= 1'b0;
               lvl_q      <= '0;
               rd_ptr     <= '0;
               wr_ptr     <= '0;
`endif
            end else begin
               if (head_from_buf) begin
                  head_data <= mem[rd_ptr];
                  rd_ptr    <= ptr_inc(rd_ptr);
               end else if (head_from_in) begin
                  head_data <= in_data;
               end
               if (buf_wr)
                  wr_ptr <= ptr_inc(wr_ptr);
               head_valid <= head_from_buf | head_from_in | (head_valid & ~pop);
               lvl_q      <= lvl_q + LW'(push) - LW'(pop);
            end
         end

         // Storage array carries no reset; validity is tracked by level.
         always_ff @(posedge clk) begin
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
            if (buf_wr & ~flush)
               mem[wr_ptr] <= in_data;
`else
            if (buf_wr)
               mem[wr_ptr] <= in_data;
`endif
         end
      end
   endgenerate

endmodule

// File: tb/tb_armleocpu_skid_fifo.sv
// Bench for armleocpu_skid_fifo: instances with DEPTH 2,3,4,5 plus one
// pass-through instance, a queue-based reference model, a vector table and
// hand-written sequences for fill/drain, streaming, reset and flush.
module tb_armleocpu_skid_fifo;
   localparam int NI = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic [NI-1:0]      iv, ordy, ir, ov;
   logic [NI-1:0][7:0] id, od, lvl;
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
   logic [NI-1:0]      fl;
`endif

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] mq[$];
   logic [7:0] dut_out[$];

   function automatic int dep_of(input int g);
      case (g)
         0: return 2;
         1: return 3;
         2: return 4;
         3: return 5;
         default: return 2;
      endcase
   endfunction

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int D = dep_of(g);
      localparam int L = $clog2(D + 1);
      logic [L-1:0] lv;
      armleocpu_skid_fifo #(.PASSTHROUGH((g == 4) ? 1 : 0), .DW(8), .DEPTH(D)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .in_valid(iv[g]), .in_data(id[g]), .in_ready(ir[g]),
         .out_valid(ov[g]), .out_data(od[g]), .out_ready(ordy[g]),
         .level(lv)
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
         , .flush(fl[g])
`endif
      );
      assign lvl[g] = 8'(lv);
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // One clock on instance k: advance the model, record DUT output words,
   // then compare every visible output with the model.
   task automatic cyc(input int k);
      bit push, pop, f;
      logic [7:0] d;
      f = 1'b0;
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
      f = fl[k];
`endif
      d    = id[k];
      push = iv[k] && (mq.size() != dep_of(k));
      pop  = (mq.size() != 0) && ordy[k];
      if (ov[k] && ordy[k] && !f) dut_out.push_back(od[k]);
      @(posedge clk); #1;
      if (f) mq.delete();
      else begin
         if (pop) void'(mq.pop_front());
         if (push) mq.push_back(d);
      end
      chk("out_valid", int'(ov[k]), (mq.size() != 0) ? 1 : 0);
      chk("level", int'(lvl[k]), mq.size());
      chk("in_ready", int'(ir[k]), (mq.size() != dep_of(k)) ? 1 : 0);
      if (mq.size() != 0) chk("out_data", int'(od[k]), int'(mq[0]));
   endtask

   task automatic do_reset();
      iv = '0; ordy = '0; id = '0;
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
      fl = '0;
`endif
      @(posedge clk); #1;
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      mq.delete();
      dut_out.delete();
   endtask

   typedef struct {
      logic iv; logic [7:0] id; logic ordy;
      logic ov; logic [7:0] od; logic [7:0] lvl; logic ir;
   } vec_t;
   vec_t tbl[10];

   initial begin
      // DEPTH=2 vectors: {in_valid, in_data, out_ready, exp out_valid,
      // exp out_data (checked when valid), exp level, exp in_ready}
      tbl[0] = '{1'b1, 8'hA1, 1'b1, 1'b1, 8'hA1, 8'd1, 1'b1};
      tbl[1] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1};
      tbl[2] = '{1'b1, 8'hB2, 1'b0, 1'b1, 8'hB2, 8'd1, 1'b1};
      tbl[3] = '{1'b1, 8'hC3, 1'b0, 1'b1, 8'hB2, 8'd2, 1'b0};
      tbl[4] = '{1'b1, 8'hD4, 1'b0, 1'b1, 8'hB2, 8'd2, 1'b0};
      tbl[5] = '{1'b1, 8'hD4, 1'b1, 1'b1, 8'hC3, 8'd1, 1'b1};
      tbl[6] = '{1'b1, 8'hD4, 1'b1, 1'b1, 8'hD4, 8'd1, 1'b1};
      tbl[7] = '{1'b1, 8'hE5, 1'b0, 1'b1, 8'hD4, 8'd2, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hE5, 8'd1, 1'b1};
      tbl[9] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 8'd0, 1'b1};

      // Reset state; pushes offered during reset must not land.
      rst_n = 1'b1;
      iv = '1; ordy = '0;
      for (int g = 0; g < NI; g++) id[g] = 8'hAA;
`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
      fl = '0;
`endif
      #2 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      for (int g = 0; g < 4; g++) begin
         chk("rst_out_valid", int'(ov[g]), 0);
         chk("rst_level", int'(lvl[g]), 0);
         chk("rst_in_ready", int'(ir[g]), 1);
         chk("rst_out_data", int'(od[g]), 0);
      end
      iv = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Vector table on DEPTH=2
      do_reset();
      for (int i = 0; i < 10; i++) begin
         iv[0] = tbl[i].iv; id[0] = tbl[i].id; ordy[0] = tbl[i].ordy;
         @(posedge clk); #1;
         chk($sformatf("tbl%0d_valid", i), int'(ov[0]), int'(tbl[i].ov));
         chk($sformatf("tbl%0d_level", i), int'(lvl[0]), int'(tbl[i].lvl));
         chk($sformatf("tbl%0d_ready", i), int'(ir[0]), int'(tbl[i].ir));
         if (tbl[i].ov) chk($sformatf("tbl%0d_data", i), int'(od[0]), int'(tbl[i].od));
      end

      // Pass-through instance: pure wires
      for (int i = 0; i < 8; i++) begin
         logic a, c; logic [7:0] b;
         a = 1'($urandom); b = 8'($urandom); c = 1'($urandom);
         iv[4] = a; id[4] = b; ordy[4] = c;
         #1;
         chk("pt_valid", int'(ov[4]), int'(a));
         chk("pt_data", int'(od[4]), int'(b));
         chk("pt_ready", int'(ir[4]), int'(c));
         chk("pt_level", int'(lvl[4]), 0);
      end
      iv[4] = 1'b0; ordy[4] = 1'b0;

      // DEPTH=4 fill, overflow attempt, drain in order
      do_reset();
      for (int i = 0; i < 4; i++) begin
         iv[2] = 1'b1; id[2] = 8'h11 + 8'(i); cyc(2);
      end
      id[2] = 8'h15; cyc(2);
      chk("t2_full_level", int'(lvl[2]), 4);
      chk("t2_full_ready", int'(ir[2]), 0);
      iv[2] = 1'b0; ordy[2] = 1'b1;
      for (int i = 0; i < 5; i++) cyc(2);
      chk("t2_count", dut_out.size(), 4);
      for (int i = 0; i < 4 && i < dut_out.size(); i++)
         chk("t2_order", int'(dut_out[i]), 8'h11 + i);

      // DEPTH=3 streaming, no bubbles
      do_reset();
      iv[1] = 1'b1; ordy[1] = 1'b1;
      for (int i = 0; i < 100; i++) begin
         id[1] = 8'(i); cyc(1);
         chk("t3_level", int'(lvl[1]), 1);
         chk("t3_data", int'(od[1]), i);
      end
      iv[1] = 1'b0; cyc(1);
      chk("t3_count", dut_out.size(), 100);
      for (int i = 0; i < dut_out.size(); i++)
         if (dut_out[i] != 8'(i)) chk("t3_seq", int'(dut_out[i]), i);

      // Asynchronous reset mid-cycle on DEPTH=4
      do_reset();
      for (int i = 0; i < 3; i++) begin
         iv[2] = 1'b1; id[2] = 8'h21 + 8'(i); cyc(2);
      end
      chk("t5_pre_level", int'(lvl[2]), 3);
      iv[2] = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("t5_valid", int'(ov[2]), 0);
      chk("t5_level", int'(lvl[2]), 0);
      chk("t5_data", int'(od[2]), 0);
      #1 rst_n = 1'b1;
      mq.delete(); dut_out.delete();
      iv[2] = 1'b1; id[2] = 8'h77; cyc(2);
      iv[2] = 1'b0; ordy[2] = 1'b1; cyc(2); cyc(2);
      chk("t5_count", dut_out.size(), 1);
      if (dut_out.size() > 0) chk("t5_word", int'(dut_out[0]), 8'h77);

`ifdef ARMLEOCPU_SKID_FIFO_FLUSH_EN
      // Flush wins over a simultaneous push
      do_reset();
      for (int i = 0; i < 3; i++) begin
         iv[2] = 1'b1; id[2] = 8'h31 + 8'(i); cyc(2);
      end
      id[2] = 8'h99; fl[2] = 1'b1; cyc(2);
      fl[2] = 1'b0;
      chk("t6_level", int'(lvl[2]), 0);
      chk("t6_valid", int'(ov[2]), 0);
      id[2] = 8'h55; cyc(2);
      iv[2] = 1'b0; ordy[2] = 1'b1;
      for (int i = 0; i < 3; i++) cyc(2);
      chk("t6_count", dut_out.size(), 1);
      if (dut_out.size() > 0) chk("t6_word", int'(dut_out[0]), 8'h55);
`endif

      // Random traffic on DEPTH=5 against the queue model
      do_reset();
      begin
         logic [7:0] sent[$];
         int pushed, cycles;
         pushed = 0; cycles = 0;
         while (pushed < 10000 && cycles < 60000) begin
            logic [7:0] hold;
            bit held;
            iv[3] = 1'($urandom); id[3] = 8'($urandom); ordy[3] = 1'($urandom);
            if (iv[3] && mq.size() != 5) begin
               sent.push_back(id[3]);
               pushed++;
            end
            held = ov[3] && !ordy[3];
            hold = od[3];
            cyc(3);
            if (held) chk("rand_hold", int'(od[3]), int'(hold));
            cycles++;
         end
         chk("rand_done", pushed, 10000);
         iv[3] = 1'b0; ordy[3] = 1'b1;
         for (int i = 0; i < 8; i++) cyc(3);
         chk("rand_count", dut_out.size(), sent.size());
         for (int i = 0; i < sent.size() && i < dut_out.size(); i++)
            if (dut_out[i] != sent[i]) chk("rand_word", int'(dut_out[i]), int'(sent[i]));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
